mux_nx1_reg: RTL
================

Name: mux_nx1_reg

Overview:
Parametrised N:1 data selector with a registered output stage and a valid/ready handshake on every channel. It generalises the 2:1 combinational mux to N channels of WIDTH bits. Two modes are supported: manual select (external sel) and round-robin arbitration among valid channels. It sits between multiple producer streams and a single consumer, and absorbs consumer backpressure.

Parameters:
WIDTH, 8, data bits per channel
N, 4, number of input channels (N >= 2)
SELW, $clog2(N), width of select and channel-ID fields (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  packed channel data; channel i is bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready (combinational)
sel  input  SELW  manual channel select (mode=0)
mode  input  1  0 = manual select, 1 = round-robin
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  channel index of the word in out_data
out_valid  output  1  output word valid
out_ready  input  1  consumer ready

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. While rst=1, in_ready is forced to all-zeros. A word held at reset is discarded.
- Output slot: slot_free = !out_valid || out_ready.
- Manual mode (mode=0): in_ready[i] = slot_free && (i == sel). in_ready is independent of in_valid. If sel >= N, no channel is ready and no transfer occurs.
- Round-robin mode (mode=1): grant g is the first i with in_valid[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1. in_ready[g] = slot_free; all other bits are 0. If no channel is valid, in_ready is 0.
- Transfer: occurs at a clock edge when in_valid[k] && in_ready[k]. On transfer: out_data<=in_data[k], out_ch<=k, out_valid<=1. Latency is 1 cycle from accept to out_valid. Throughput is 1 word/cycle.
- Pointer: it updates only on a round-robin transfer, to ptr<=(g+1) mod N, wrapping from N-1 to 0. It holds in manual mode and when no transfer occurs.
- Drain without reload: if out_valid && out_ready and no transfer occurs, then out_valid<=0. out_data and out_ch hold their last values.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old. There is no bubble.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable and in_ready is all-zeros.
- Mode or sel change: takes effect combinationally in the same cycle. ptr is retained across mode changes.
- At most one transfer per cycle. Input data is never duplicated or dropped once accepted.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=4'b0000. Deassert rst -> the first transfer occurs on the next edge.
2. Manual: mode=0, sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. One cycle later out_valid=1, out_data=0xA5, out_ch=2. Then sel=1 with in_valid[1]=0 -> no transfer, and out_valid falls to 0 after the drain.
3. Round-robin fairness: mode=1, all valid, channel data 0x10..0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
4. Round-robin skip and wrap: in_valid=4'b1010 starting from ptr=0 -> grants 1,3,1,3. in_valid=4'b0000 for 1 cycle -> no grant and ptr unchanged.
5. Backpressure: out_valid=1 with 0x11, out_ready=0 for 3 cycles -> out_data=0x11 stable and in_ready=0. Raise out_ready with ch2 valid -> a same-cycle drain and load occurs, out_valid stays 1, and out_data=0x12.
6. Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and ptr=0. After release in mode=1, the first grant is the lowest valid channel.

Source files
------------

// File: rtl/mux_nx1_reg_if.sv
// Bus bundle for mux_nx1_reg: N producer channels in, one consumer stream out.
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, driven by the selector
//   sel, mode : manual channel select / 0 = manual, 1 = round-robin
//   out_data  : registered selected word
//   out_ch    : channel index of out_data
//   out_valid : output word valid
//   out_ready : consumer ready
// master = producers + consumer side, slave = the selector.
interface mux_nx1_reg_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nx1_reg.sv
// N:1 data selector with a single registered output slot and valid/ready on
// every channel. Manual mode follows bus.sel; round-robin mode grants the first
// valid channel at or after the rotating pointer.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mux_nx1_reg_if slave modport (see interface header)
module mux_nx1_reg #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_reg_if.slave  bus
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_slot_free;
    logic [2*N-1:0]   w_valid_rot;
    logic [SELW-1:0]  w_off;
    logic [SELW:0]    w_sum;
    logic [SELW-1:0]  w_grant;
    logic             w_any;
    logic [N-1:0]     w_ready;
    logic             w_xfer;
    logic [SELW-1:0]  w_xfer_ch;
    logic [WIDTH-1:0] w_xfer_data;
    logic [SELW-1:0]  w_ptr_next;

    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Rotate the valid vector so the pointer channel lands at bit 0; the
    // lowest set bit is then the offset of the round-robin winner.
    assign w_valid_rot = {bus.in_valid, bus.in_valid} >> r_ptr;
    assign w_any       = |bus.in_valid;

    always_comb begin
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_valid_rot[j]) begin
                w_off = SELW'(j);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (SELW+1)'(N)) begin
            w_sum = w_sum - (SELW+1)'(N);
        end
        w_grant = w_sum[SELW-1:0];
    end

    // Manual mode matches sel against each index, so an out-of-range sel
    // simply selects nothing.
    always_comb begin
        w_ready = '0;
        if (!rst && w_slot_free) begin
            if (bus.mode) begin
                if (w_any) begin
                    w_ready[w_grant] = 1'b1;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (bus.sel == SELW'(i)) begin
                        w_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_xfer      = 1'b0;
        w_xfer_ch   = '0;
        w_xfer_data = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_valid[i] && w_ready[i]) begin
                w_xfer      = 1'b1;
                w_xfer_ch   = SELW'(i);
                w_xfer_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_xfer_data;
                r_out_ch    <= w_xfer_ch;
                if (bus.mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule
